gcd_controller: RTL

//  Control FSM that sequences the 16-bit subtractive GCD datapath (registers A/B, operand muxes,

---
 rtl/gcd_pkg.sv | 10 +
 rtl/gcd_iter_counter.sv | 19 +
 rtl/gcd_controller.sv | 95 +++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding, datapath mux selects and default sizing for the GCD controller
package gcd_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_B, COMPUTE, DONE} state_t;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    localparam logic SEL_SUB = 1'b0;
    localparam logic SEL_DATA = 1'b1;
    localparam int CNT_W_DEF = 16;
    localparam int MAX_ITER_DEF = 65535;
endpackage

// File: rtl/gcd_iter_counter.sv
// gcd_iter_counter: subtraction counter with clear/increment/hold and a limit flag
module gcd_iter_counter #(
    parameter int CNT_W = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= count + 1'b1;
    end
    assign at_max = count == CNT_W'(MAX_ITER);
endmodule

// File: rtl/gcd_controller.sv
// gcd_controller: FSM sequencing the subtractive GCD datapath with operand/result handshakes
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             ldA,
    output logic             ldB,
    output logic             sel1,
    output logic             sel2,
    output logic             sel_in,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             err_timeout,
    output logic [CNT_W-1:0] iter_count
);
    state_t state, next_state;
    logic cnt_clr, cnt_inc, set_err, at_max;

    gcd_iter_counter #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) u_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_inc), .count(iter_count), .at_max(at_max)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_timeout <= 1'b0;
        else if (cnt_clr) err_timeout <= 1'b0;
        else if (set_err) err_timeout <= 1'b1;
    end

    always_comb begin
        next_state = state;
        in_ready = 1'b0;
        done_valid = state == DONE;
        ldA = 1'b0;
        ldB = 1'b0;
        sel1 = SEL_A;
        sel2 = SEL_A;
        sel_in = SEL_SUB;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        set_err = 1'b0;
        if (abort) next_state = IDLE;
        else case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sel_in = SEL_DATA;
                    ldA = 1'b1;
                    cnt_clr = 1'b1;
                    next_state = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sel_in = SEL_DATA;
                    ldB = 1'b1;
                    next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                // eq wins over gt, gt over lt, should the comparator ever report several
                if (eq) next_state = DONE;
                else if (gt || lt) begin
                    if (at_max) begin
                        set_err = 1'b1;
                        next_state = DONE;
                    end else begin
                        sel1 = gt ? SEL_A : SEL_B;
                        sel2 = gt ? SEL_B : SEL_A;
                        ldA = gt;
                        ldB = !gt;
                        cnt_inc = 1'b1;
                    end
                end
            end
            DONE: if (done_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
endmodule
